// File: rtl/biu_arb_pkg.sv
// biu_arb_pkg: shared definitions for the system-bus arbiter.
//   - FSM state encodings (legacy 3-bit values, bit 2 marks a locked hold)
//   - owner codes reported on the debug owner port
//   - opc_biu bus opcodes shared with ins_dec and the BIU
//   - owner_of(): maps an FSM state onto its owner code
package biu_arb_pkg;

    localparam logic [2:0] ST_IDLE  = 3'b000;
    localparam logic [2:0] ST_BUSY0 = 3'b001;
    localparam logic [2:0] ST_BUSY1 = 3'b010;
    localparam logic [2:0] ST_HOLD0 = 3'b101;
    localparam logic [2:0] ST_HOLD1 = 3'b110;

    localparam logic [1:0] OWN_NONE = 2'b00;
    localparam logic [1:0] OWN_M0   = 2'b01;
    localparam logic [1:0] OWN_M1   = 2'b10;

    localparam logic [2:0] OPC_NOP   = 3'b000;
    localparam logic [2:0] OPC_FETCH = 3'b001;
    localparam logic [2:0] OPC_LB    = 3'b010;
    localparam logic [2:0] OPC_LH    = 3'b011;
    localparam logic [2:0] OPC_LW    = 3'b100;
    localparam logic [2:0] OPC_SB    = 3'b101;
    localparam logic [2:0] OPC_SH    = 3'b110;
    localparam logic [2:0] OPC_SW    = 3'b111;

    function automatic logic [1:0] owner_of(input logic [2:0] st);
        logic [1:0] own;
        case (st)
            ST_BUSY0, ST_HOLD0: own = OWN_M0;
            ST_BUSY1, ST_HOLD1: own = OWN_M1;
            default:            own = OWN_NONE;
        endcase
        return own;
    endfunction

endpackage

// File: rtl/biu_arb_timer.sv
// arb_timer: loadable up-counter with synchronous clear and terminal-count flag.
//   clk_i      clock
//   rst_i      synchronous active-high reset (count -> 0)
//   clr_i      clear count to 0 (highest priority after reset)
//   en_i       count enable; the count saturates at MAX
//   load_i     load load_val_i into the count
//   load_val_i value to load
//   tc_o       high while the count equals MAX
module arb_timer #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned MAX   = 255
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             clr_i,
    input  logic             en_i,
    input  logic             load_i,
    input  logic [WIDTH-1:0] load_val_i,
    output logic             tc_o
);

    logic [WIDTH-1:0] cnt_q, cnt_d;

    assign tc_o = (cnt_q == WIDTH'(MAX));

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (load_i) begin
            cnt_d = load_val_i;
        end else if (en_i && !tc_o) begin
            cnt_d = cnt_q + WIDTH'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/biu_arb.sv
// biu_arb: two-master arbiter/sequencer for the single system bus port.
//   m0_* : core BIU (fetch, load/store, AMO sequences)
//   m1_* : debug/DMA engine
//   mx_req/lock/opc/addr/wdata in, mx_rdata/rdy/err out (rdy, err: 1-cycle pulses)
//   s_req/opc/addr/wdata out to slave, s_ack/err/rdata in from slave
//   owner: debug view of current owner (00 none, 01 m0, 10 m1)
// Round-robin on contention, grant retained across locked sequences, hung slaves
// aborted after TIMEOUT cycles, idle locks dropped after LOCK_MAX cycles.
module biu_arb
    import biu_arb_pkg::*;
#(
    parameter int unsigned TIMEOUT  = 255,
    parameter int unsigned LOCK_MAX = 15
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        m0_req,
    input  logic        m0_lock,
    input  logic [2:0]  m0_opc,
    input  logic [33:0] m0_addr,
    input  logic [31:0] m0_wdata,
    output logic [31:0] m0_rdata,
    output logic        m0_rdy,
    output logic        m0_err,
    input  logic        m1_req,
    input  logic        m1_lock,
    input  logic [2:0]  m1_opc,
    input  logic [33:0] m1_addr,
    input  logic [31:0] m1_wdata,
    output logic [31:0] m1_rdata,
    output logic        m1_rdy,
    output logic        m1_err,
    output logic        s_req,
    output logic [2:0]  s_opc,
    output logic [33:0] s_addr,
    output logic [31:0] s_wdata,
    input  logic        s_ack,
    input  logic        s_err,
    input  logic [31:0] s_rdata,
    output logic [1:0]  owner
);

    localparam int unsigned TO_W = $clog2(TIMEOUT + 1);
    localparam int unsigned LK_W = $clog2(LOCK_MAX + 1);

    logic [2:0] state_q, state_d;
    logic       rr_q, rr_d;      // 0: m0 wins next contention, 1: m1
    logic       busy, hold, sel1;
    logic       cnt_clr, to_tc, lk_tc;

    assign busy    = (state_q == ST_BUSY0) || (state_q == ST_BUSY1);
    assign hold    = (state_q == ST_HOLD0) || (state_q == ST_HOLD1);
    assign sel1    = (state_q == ST_BUSY1);
    assign cnt_clr = (state_d != state_q);

    arb_timer #(.WIDTH(TO_W), .MAX(TIMEOUT)) u_timeout (
        .clk_i      (clk),
        .rst_i      (rst),
        .clr_i      (cnt_clr),
        .en_i       (busy),
        .load_i     (1'b0),
        .load_val_i ('0),
        .tc_o       (to_tc)
    );

    arb_timer #(.WIDTH(LK_W), .MAX(LOCK_MAX)) u_lock (
        .clk_i      (clk),
        .rst_i      (rst),
        .clr_i      (cnt_clr),
        .en_i       (hold),
        .load_i     (1'b0),
        .load_val_i ('0),
        .tc_o       (lk_tc)
    );

    always_comb begin
        state_d = state_q;
        rr_d    = rr_q;
        case (state_q)
            ST_IDLE: begin
                if (m0_req && m1_req) begin
                    state_d = rr_q ? ST_BUSY1 : ST_BUSY0;
                    rr_d    = ~rr_q;
                end else if (m0_req) begin
                    state_d = ST_BUSY0;
                end else if (m1_req) begin
                    state_d = ST_BUSY1;
                end
            end
            // An ack in the expiry cycle still completes normally.
            ST_BUSY0: begin
                if (s_ack)      state_d = m0_lock ? ST_HOLD0 : ST_IDLE;
                else if (to_tc) state_d = ST_IDLE;
            end
            ST_BUSY1: begin
                if (s_ack)      state_d = m1_lock ? ST_HOLD1 : ST_IDLE;
                else if (to_tc) state_d = ST_IDLE;
            end
            ST_HOLD0: begin
                if (m0_req)                 state_d = ST_BUSY0;
                else if (!m0_lock || lk_tc) state_d = ST_IDLE;
            end
            ST_HOLD1: begin
                if (m1_req)                 state_d = ST_BUSY1;
                else if (!m1_lock || lk_tc) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            rr_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            rr_q    <= rr_d;
        end
    end

    // Outputs are gated by rst so the bus drops in the cycle reset is sampled.
    // In the timeout cycle s_req is already low while the error pulse goes back.
    always_comb begin
        s_req    = 1'b0;
        s_opc    = '0;
        s_addr   = '0;
        s_wdata  = '0;
        m0_rdy   = 1'b0;
        m0_err   = 1'b0;
        m0_rdata = '0;
        m1_rdy   = 1'b0;
        m1_err   = 1'b0;
        m1_rdata = '0;
        owner    = OWN_NONE;
        if (!rst) begin
            owner = owner_of(state_q);
            if (busy) begin
                if (!to_tc) begin
                    s_req   = 1'b1;
                    s_opc   = sel1 ? m1_opc   : m0_opc;
                    s_addr  = sel1 ? m1_addr  : m0_addr;
                    s_wdata = sel1 ? m1_wdata : m0_wdata;
                end
                if (s_ack || to_tc) begin
                    if (sel1) begin
                        m1_rdy   = 1'b1;
                        m1_err   = s_ack ? s_err : 1'b1;
                        m1_rdata = s_ack ? s_rdata : '0;
                    end else begin
                        m0_rdy   = 1'b1;
                        m0_err   = s_ack ? s_err : 1'b1;
                        m0_rdata = s_ack ? s_rdata : '0;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_biu_arb.sv
// tb_biu_arb: directed self-checking bench for biu_arb with a completion scoreboard.
module tb_biu_arb;
    import biu_arb_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        m0_req, m0_lock;
    logic [2:0]  m0_opc;
    logic [33:0] m0_addr;
    logic [31:0] m0_wdata, m0_rdata;
    logic        m0_rdy, m0_err;
    logic        m1_req, m1_lock;
    logic [2:0]  m1_opc;
    logic [33:0] m1_addr;
    logic [31:0] m1_wdata, m1_rdata;
    logic        m1_rdy, m1_err;
    logic        s_req;
    logic [2:0]  s_opc;
    logic [33:0] s_addr;
    logic [31:0] s_wdata;
    logic        s_ack, s_err;
    logic [31:0] s_rdata;
    logic [1:0]  owner;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        int          m;
        logic [31:0] rdata;
        logic        err;
    } exp_t;
    exp_t sb[$];

    biu_arb #(.TIMEOUT(255), .LOCK_MAX(15)) dut (
        .clk(clk), .rst(rst),
        .m0_req(m0_req), .m0_lock(m0_lock), .m0_opc(m0_opc), .m0_addr(m0_addr),
        .m0_wdata(m0_wdata), .m0_rdata(m0_rdata), .m0_rdy(m0_rdy), .m0_err(m0_err),
        .m1_req(m1_req), .m1_lock(m1_lock), .m1_opc(m1_opc), .m1_addr(m1_addr),
        .m1_wdata(m1_wdata), .m1_rdata(m1_rdata), .m1_rdy(m1_rdy), .m1_err(m1_err),
        .s_req(s_req), .s_opc(s_opc), .s_addr(s_addr), .s_wdata(s_wdata),
        .s_ack(s_ack), .s_err(s_err), .s_rdata(s_rdata), .owner(owner)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish (observed hang, required $finish)");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic nxt();
        @(negedge clk);
    endtask

    task automatic push(input int m, input logic [31:0] d, input logic e);
        exp_t x;
        x.m = m; x.rdata = d; x.err = e;
        sb.push_back(x);
    endtask

    task automatic expect_done(input string tag, output int m);
        exp_t e;
        m = 0;
        check({tag, "_sb_pending"}, 64'(sb.size() != 0), 64'd1);
        if (sb.size() != 0) begin
            e = sb.pop_front();
            m = e.m;
            if (e.m == 1) begin
                check({tag, "_m1_rdy"},   64'(m1_rdy),   64'd1);
                check({tag, "_m0_rdy"},   64'(m0_rdy),   64'd0);
                check({tag, "_m1_rdata"}, 64'(m1_rdata), 64'(e.rdata));
                check({tag, "_m1_err"},   64'(m1_err),   64'(e.err));
            end else begin
                check({tag, "_m0_rdy"},   64'(m0_rdy),   64'd1);
                check({tag, "_m1_rdy"},   64'(m1_rdy),   64'd0);
                check({tag, "_m0_rdata"}, 64'(m0_rdata), 64'(e.rdata));
                check({tag, "_m0_err"},   64'(m0_err),   64'(e.err));
            end
        end
    endtask

    // Slave acks the transaction in flight; the completing master drops req.
    task automatic ack(input logic [31:0] d, input logic e, input string tag);
        int m;
        nxt();
        s_ack = 1'b1; s_rdata = d; s_err = e;
        #1;
        expect_done(tag, m);
        if (m == 1) m1_req = 1'b0;
        else        m0_req = 1'b0;
        nxt();
        s_ack = 1'b0; s_rdata = '0; s_err = 1'b0;
    endtask

    initial begin
        int m;
        int cycles;
        int hold_cycles;
        bit done;

        rst = 1'b1;
        m0_req = 1'b0; m0_lock = 1'b0; m0_opc = OPC_NOP; m0_addr = '0; m0_wdata = '0;
        m1_req = 1'b0; m1_lock = 1'b0; m1_opc = OPC_NOP; m1_addr = '0; m1_wdata = '0;
        s_ack = 1'b0; s_err = 1'b0; s_rdata = '0;

        // Reset
        nxt(); #1;
        check("rst_s_req",  64'(s_req),  64'd0);
        check("rst_owner",  64'(owner),  64'd0);
        check("rst_m0_rdy", 64'(m0_rdy), 64'd0);
        nxt(); rst = 1'b0; #1;
        check("idle_owner",  64'(owner),  64'd0);
        check("idle_s_req",  64'(s_req),  64'd0);
        check("idle_s_addr", 64'(s_addr), 64'd0);

        // m0 read alone
        nxt();
        m0_req = 1'b1; m0_opc = OPC_LW; m0_addr = 34'h000001000;
        push(0, 32'hDEADBEEF, 1'b0);
        #1;
        check("t1_lat0_s_req", 64'(s_req), 64'd0);
        nxt(); #1;
        check("t1_s_req",  64'(s_req),  64'd1);
        check("t1_s_addr", 64'(s_addr), 64'h000001000);
        check("t1_s_opc",  64'(s_opc),  64'(OPC_LW));
        check("t1_owner",  64'(owner),  64'(OWN_M0));
        ack(32'hDEADBEEF, 1'b0, "t1");
        #1;
        check("t1_idle_owner", 64'(owner),    64'd0);
        check("t1_idle_s_req", 64'(s_req),    64'd0);
        check("t1_idle_rdy",   64'(m0_rdy),   64'd0);
        check("t1_idle_rdata", 64'(m0_rdata), 64'd0);

        // Contention round 1: pointer at m0
        nxt();
        m0_req = 1'b1; m0_addr = 34'h000002000;
        m1_req = 1'b1; m1_opc = OPC_LW; m1_addr = 34'h200003000;
        push(0, 32'h11110000, 1'b0);
        push(1, 32'h22220000, 1'b0);
        nxt(); #1;
        check("t2a_owner",  64'(owner),  64'(OWN_M0));
        check("t2a_s_addr", 64'(s_addr), 64'h000002000);
        ack(32'h11110000, 1'b0, "t2a");
        #1;
        check("t2a_gap_owner", 64'(owner), 64'd0);
        nxt(); #1;
        check("t2b_owner",  64'(owner),  64'(OWN_M1));
        check("t2b_s_addr", 64'(s_addr), 64'h200003000);
        ack(32'h22220000, 1'b0, "t2b");

        // Contention round 2: pointer flipped to m1
        nxt();
        m0_req = 1'b1; m1_req = 1'b1;
        push(1, 32'h33330000, 1'b0);
        push(0, 32'h44440000, 1'b0);
        nxt(); #1;
        check("t2c_owner", 64'(owner), 64'(OWN_M1));
        ack(32'h33330000, 1'b0, "t2c");
        nxt(); #1;
        check("t2d_owner", 64'(owner), 64'(OWN_M0));
        ack(32'h44440000, 1'b0, "t2d");

        // Locked AMO with m1 requesting throughout
        nxt();
        m0_req = 1'b1; m0_lock = 1'b1; m0_opc = OPC_LW; m0_addr = 34'h000004000;
        m1_req = 1'b1; m1_addr = 34'h200005000;
        push(0, 32'h55556666, 1'b0);
        push(0, 32'h00000000, 1'b1);
        push(1, 32'h77778888, 1'b0);
        nxt(); #1;
        check("t3rd_owner", 64'(owner), 64'(OWN_M0));
        ack(32'h55556666, 1'b0, "t3rd");
        #1;
        check("t3_hold_owner", 64'(owner), 64'(OWN_M0));
        check("t3_hold_s_req", 64'(s_req), 64'd0);
        nxt();
        s_ack = 1'b1; s_rdata = 32'h12345678;
        #1;
        check("t3_late_ack_m0_rdy",   64'(m0_rdy),   64'd0);
        check("t3_late_ack_m1_rdy",   64'(m1_rdy),   64'd0);
        check("t3_late_ack_m0_rdata", 64'(m0_rdata), 64'd0);
        nxt();
        s_ack = 1'b0; s_rdata = '0;
        #1;
        check("t3_hold2_owner", 64'(owner), 64'(OWN_M0));
        nxt();
        m0_req = 1'b1; m0_lock = 1'b0; m0_opc = OPC_SW; m0_wdata = 32'hCAFEF00D;
        #1;
        check("t3_hold3_s_req", 64'(s_req), 64'd0);
        nxt(); #1;
        check("t3wr_s_req",   64'(s_req),   64'd1);
        check("t3wr_owner",   64'(owner),   64'(OWN_M0));
        check("t3wr_s_opc",   64'(s_opc),   64'(OPC_SW));
        check("t3wr_s_wdata", 64'(s_wdata), 64'hCAFEF00D);
        ack(32'h00000000, 1'b1, "t3wr");
        #1;
        check("t3_gap_owner", 64'(owner), 64'd0);
        nxt(); #1;
        check("t3m1_owner",  64'(owner),  64'(OWN_M1));
        check("t3m1_s_addr", 64'(s_addr), 64'h200005000);
        ack(32'h77778888, 1'b0, "t3m1");

        // Timeout on m1
        nxt();
        m1_req = 1'b1; m1_opc = OPC_LW; m1_addr = 34'h3FFFFFFFC;
        push(1, 32'h00000000, 1'b1);
        cycles = 0; done = 1'b0;
        for (int k = 0; k < 400 && !done; k++) begin
            nxt(); #1;
            if (m1_rdy) done = 1'b1;
            else if (s_req) cycles++;
        end
        check("t4_done",        64'(done),   64'd1);
        check("t4_busy_cycles", 64'(cycles), 64'd255);
        check("t4_s_req_drop",  64'(s_req),  64'd0);
        expect_done("t4", m);
        m1_req = 1'b0;
        nxt(); #1;
        check("t4_one_pulse", 64'(m1_rdy), 64'd0);
        check("t4_owner",     64'(owner),  64'd0);
        check("t4_s_req",     64'(s_req),  64'd0);

        // Lock expiry with m1 pending
        nxt();
        m0_req = 1'b1; m0_lock = 1'b1; m0_opc = OPC_LW; m0_addr = 34'h000006000;
        push(0, 32'h9999AAAA, 1'b0);
        nxt(); #1;
        check("t5_owner", 64'(owner), 64'(OWN_M0));
        m1_req = 1'b1; m1_addr = 34'h200007000;
        push(1, 32'hBBBBCCCC, 1'b0);
        ack(32'h9999AAAA, 1'b0, "t5");
        hold_cycles = 0;
        #1;
        for (int k = 0; k < 40; k++) begin
            if (owner !== OWN_M0 || s_req !== 1'b0) break;
            hold_cycles++;
            nxt(); #1;
        end
        check("t5_hold_cycles", 64'(hold_cycles), 64'd16);
        check("t5_idle_owner",  64'(owner),       64'd0);
        nxt(); #1;
        check("t5_m1_owner",  64'(owner),  64'(OWN_M1));
        check("t5_m1_s_addr", 64'(s_addr), 64'h200007000);
        m0_lock = 1'b0;
        ack(32'hBBBBCCCC, 1'b0, "t5m1");

        // Reset mid-BUSY1, then a stray ack
        nxt();
        m1_req = 1'b1; m1_addr = 34'h200008000;
        nxt(); #1;
        check("t6_busy_owner", 64'(owner), 64'(OWN_M1));
        check("t6_busy_s_req", 64'(s_req), 64'd1);
        nxt();
        rst = 1'b1;
        #1;
        check("t6_rst_s_req",  64'(s_req),  64'd0);
        check("t6_rst_owner",  64'(owner),  64'd0);
        check("t6_rst_s_addr", 64'(s_addr), 64'd0);
        m1_req = 1'b0;
        nxt();
        rst = 1'b0; s_ack = 1'b1; s_err = 1'b1; s_rdata = 32'hBAD0BAD0;
        #1;
        check("t6_stray_m0_rdy",   64'(m0_rdy),   64'd0);
        check("t6_stray_m1_rdy",   64'(m1_rdy),   64'd0);
        check("t6_stray_m1_err",   64'(m1_err),   64'd0);
        check("t6_stray_m1_rdata", 64'(m1_rdata), 64'd0);
        check("t6_stray_owner",    64'(owner),    64'd0);
        check("t6_stray_s_req",    64'(s_req),    64'd0);
        nxt();
        s_ack = 1'b0; s_err = 1'b0; s_rdata = '0;
        #1;
        check("t6_idle_owner", 64'(owner), 64'd0);

        check("sb_drained", 64'(sb.size()), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/biu_arb.md
Name: biu_arb

Overview:
- Two-master arbiter and sequencer for the single system bus port.
- Master 0 is the core BIU: instruction fetch, load/store, and AMO read-modify-write sequences.
- Master 1 is the secondary master: debug/DMA engine.
- Grants one master at a time, holds the grant across locked AMO sequences, and times out hung slaves with an access-fault error.

Parameters:
TIMEOUT, 255, cycles without slave ack before the transaction is aborted with err (counter width = clog2(TIMEOUT+1)).
LOCK_MAX, 15, max cycles a locked owner may idle between transactions before the lock is forcibly dropped.

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-high reset
m0_req  in  1  master 0 transaction request (level, held until m0_rdy)
m0_lock  in  1  master 0 keep grant after this transaction (AMO/lr-sc sequence)
m0_opc  in  3  master 0 bus opcode (same encoding as opc_biu)
m0_addr  in  34  master 0 physical address
m0_wdata  in  32  master 0 write data
m0_rdata  out  32  read data to master 0
m0_rdy  out  1  one-cycle completion pulse to master 0
m0_err  out  1  one-cycle error pulse (with m0_rdy) to master 0
m1_req, m1_lock, m1_opc, m1_addr, m1_wdata, m1_rdata, m1_rdy, m1_err  same widths/meaning for master 1
s_req  out  1  bus request to slave
s_opc  out  3  forwarded opcode
s_addr  out  34  forwarded address
s_wdata  out  32  forwarded write data
s_ack  in  1  slave completion
s_err  in  1  slave error, valid with s_ack
s_rdata  in  32  slave read data, valid with s_ack
owner  out  2  debug: 00 none, 01 m0, 10 m1

Behaviour:
- Reset, synchronous, active-high: state IDLE, owner=00, rr pointer=m0, counters=0; all outputs 0.
- States:
  - IDLE: no owner.
  - BUSY0/BUSY1: transaction in flight.
  - HOLD0/HOLD1: locked, owner retained, no transaction.
- IDLE arbitration:
  - Single requester wins.
  - Both requesting: the rr pointer side wins, and the pointer flips to the other master.
  - Transition to BUSYx on the next edge; s_req asserts that cycle. Latency from request to s_req is 1 cycle.
- BUSYx:
  - s_req/s_opc/s_addr/s_wdata driven combinationally from master x.
  - The timeout counter increments each cycle.
  - On s_ack: mx_rdy=1 the same cycle, mx_err=s_err, mx_rdata=s_rdata.
  - After ack, the next state is HOLDx if mx_lock=1, else IDLE.
- HOLDx:
  - mx_req → BUSYx next edge.
  - mx_lock=0 with no req → IDLE.
  - The other master is blocked.
  - The idle counter increments each cycle; at LOCK_MAX → IDLE.
- Timeout: BUSYx with no ack for TIMEOUT cycles → mx_rdy=1, mx_err=1, mx_rdata=0 for one cycle, s_req deasserts, next state IDLE (lock dropped).
- Late ack: an s_ack in IDLE/HOLD is ignored.
- mx_rdata is 0 when mx_rdy=0.
- Counters clear on every state change.
- Simultaneous s_ack and timeout expiry: the ack wins, err=s_err.
- A master dropping req mid-BUSY is illegal. The arbiter completes the transaction anyway and discards nothing.
- rst mid-transaction returns to IDLE the next edge. s_req drops in the same cycle that rst is sampled.

Decomposition:
- Shared package holds:
  - state encodings (IDLE=3'b000, BUSY0=3'b001, BUSY1=3'b010, HOLD0=3'b101, HOLD1=3'b110)
  - owner codes
  - opc_biu encodings, shared with ins_dec/BIU
- One sub-module, arb_timer: loadable up-counter with clear and terminal-count flag. It is instantiated twice, for the timeout and the lock idle limit.

Test Plan:
- m0 read alone: m0_req=1, addr=0x000001000 → s_req at +1 cycle; s_ack with rdata=0xDEADBEEF → m0_rdy=1 and m0_rdata=0xDEADBEEF the same cycle; state IDLE next.
- Contention: m0_req and m1_req rise together after reset → m0 served first, then m1. Repeating the pattern serves m1 first.
- Locked AMO: m0 read with lock=1, then m0 write with lock=0, while m1_req is held high throughout → m1 sees no s_req until after the m0 write ack. owner stays 01 across the gap.
- Timeout: m1 request, slave never acks → after exactly 255 BUSY cycles m1_rdy=1 and m1_err=1 for one cycle, s_req falls, owner=00.
- Lock expiry: m0 completes with lock=1, then idles for 15 cycles with req=0 → state IDLE, and a pending m1_req is granted on the next edge.
- Reset mid-BUSY1, then a stray s_ack → all outputs 0, no mx_rdy pulse, state IDLE.
